// File: rtl/dmem_responder.sv
// dmem_responder: memory-side endpoint for load/store requests from decode.
// One request at a time is accepted, held in ACCESS for LATENCY cycles, and
// answered in RESP. Byte/half/word lanes with sign/zero-extended loads over a
// word-organised internal RAM of DEPTH words.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload stable until that edge; the
// responder never drops rsp_valid or changes rdata/rsp_err before it.
//
// Optional build macro DMEM_STATS_EN adds saturating rd/wr/err counters.
// state_dbg exposes the FSM state (0=IDLE, 1=ACCESS, 2=RESP).

module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  xfer_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err,
`ifdef DMEM_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count,
`endif
  output logic [1:0]  state_dbg
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_rd;
  logic        lat_wr;
  logic [2:0]  lat_size;
  logic        lat_uns;

  logic [31:0] mem [DEPTH];

  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          req_err;
  logic [31:0]   mem_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          access_fire;
  logic          ram_we;

  assign state_dbg = state;
  assign lane      = lat_addr[1:0];
  assign idx       = lat_addr[AW+1:2];
  assign is_byte   = (lat_size == 3'd1);
  assign is_half   = (lat_size == 3'd2);
  assign is_word   = (lat_size == 3'd4);
  assign mem_word  = mem[idx];

  // The access happens on the edge that ends the last ACCESS cycle. Because
  // this is derived from the async-reset state, a reset in ACCESS kills it.
  assign access_fire = (state == S_ACCESS) && (cnt == 4'd0);
  assign ram_we      = access_fire && lat_wr && !req_err;

  // Legality check of the latched request; any hit suppresses side effects.
  always_comb begin
    req_err = 1'b0;
    if (lat_rd == lat_wr)                   req_err = 1'b1;
    if (!(is_byte || is_half || is_word))   req_err = 1'b1;
    if (is_half && lane[0])                 req_err = 1'b1;
    if (is_word && (lane != 2'b00))         req_err = 1'b1;
    if (lat_addr[31:2] >= DEPTH_W)          req_err = 1'b1;
  end

  // Load lane select and extension.
  always_comb begin
    byte_v    = mem_word[{lane, 3'b000} +: 8];
    half_v    = lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = mem_word;
    if (is_byte) begin
      load_data = lat_uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
    end else if (is_half) begin
      load_data = lat_uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
    end
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be = 4'b0000;
    wd = lat_wdata;
    if (is_byte) begin
      be = 4'b0001 << lane;
      wd = {4{lat_wdata[7:0]}};
    end else if (is_half) begin
      be = lane[1] ? 4'b1100 : 4'b0011;
      wd = {2{lat_wdata[15:0]}};
    end else if (is_word) begin
      be = 4'b1111;
    end
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rdata     <= 32'h0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_size  <= 3'd0;
      lat_uns   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_rd    <= mem_read;
            lat_wr    <= mem_write;
            lat_size  <= xfer_size;
            lat_uns   <= load_unsigned;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= req_err;
            rdata     <= (req_err || lat_wr) ? 32'h0 : load_data;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  logic rsp_fire;
  assign rsp_fire = (state == S_RESP) && rsp_valid && rsp_ready;

  // Saturating per-class counters, bumped when the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count  <= 16'h0;
      wr_count  <= 16'h0;
      err_count <= 16'h0;
    end else if (rsp_fire) begin
      if (rsp_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'h1;
      end else if (lat_rd) begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'h1;
      end else begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'h1;
      end
    end
  end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side endpoint for the load/store controls (mem_read, mem_write, xfer_size) produced by instruction decode.
- Accepts one request at a time over a valid/ready handshake, holds it for a fixed access latency, then returns a response with valid/ready.
- Handles byte, half and word lanes, with load sign- or zero-extension.
- Sits between the execute/memory stage and a word-organised internal RAM.

Parameters:
DEPTH, 1024, number of 32-bit words in the internal RAM (power of 2)
LATENCY, 2, cycles spent in ACCESS per request; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
mem_read  in  1  load request
mem_write  in  1  store request
xfer_size  in  3  bytes to transfer: 1, 2 or 4
load_unsigned  in  1  zero-extend the load (lbu/lhu); otherwise sign-extend
addr  in  32  byte address
wdata  in  32  store data; the low xfer_size bytes are used
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  request was illegal; no memory side effect

Behaviour:
- FSM states IDLE, ACCESS, RESP. Reset enters IDLE.
- Reset values: req_ready=1, rsp_valid=0, rdata=0, rsp_err=0, internal counter=0.
- RAM contents are not reset.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, wdata, mem_read, mem_write, xfer_size, load_unsigned.
  - Load the counter with LATENCY-1 and go to ACCESS.
- ACCESS:
  - req_ready=0.
  - On each edge the counter decrements.
  - On the edge where the counter is 0, perform the access and go to RESP.
  - rsp_valid therefore rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid=1; rdata and rsp_err are stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - rsp_valid holds until the handshake completes; rdata and rsp_err do not change while rsp_valid=1.
  - The next request cannot be accepted in the handshake cycle, because req_ready is 0 in RESP.
- Error conditions (any one sets rsp_err=1):
  - mem_read and mem_write both 1, or both 0.
  - xfer_size not in {1,2,4}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
- On error: no RAM write, rdata=0.
- Word index is addr[$clog2(DEPTH)+1:2]; the lane is addr[1:0].
- Store:
  - Byte writes wdata[7:0] to lane addr[1:0].
  - Half writes wdata[15:0] to lanes addr[1] * 2 and +1.
  - Word writes all four lanes.
  - Other lanes are unchanged.
  - Store response: rdata=0, rsp_err=0.
- Load:
  - Select the byte or half from the lane.
  - load_unsigned=1 zero-extends; load_unsigned=0 sign-extends from bit 7 or bit 15.
  - A word load returns the full word.
- Read-after-write: a load accepted after a store's response handshake returns the stored data.
- Reset asserted mid-operation (ACCESS or RESP):
  - Go to IDLE immediately; rsp_valid drops asynchronously.
  - A store still in ACCESS is dropped (no partial write).
  - A store already completed in RAM remains.
- Inputs other than req_valid are don't-care outside the accept cycle.

Optional Feature:
- Macro DMEM_STATS_EN.
- When defined, adds three outputs:
  - rd_count [15:0]: successful loads.
  - wr_count [15:0]: successful stores.
  - err_count [15:0]: errored requests.
- Each counter increments on the rsp_valid&&rsp_ready handshake of its request class.
- Counters saturate at 16'hFFFF.
- Counters reset to 0 on rst_n low.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then word store/load:
  - Stimulus: store xfer_size=4, addr=0x10, wdata=0xDEADBEEF; rsp_ready=1.
  - Response: rsp_valid exactly 2 cycles after the accept edge, rsp_err=0.
  - Then a word load from 0x10 returns rdata=0xDEADBEEF.
- Byte lanes and extension:
  - Stimulus: store byte 0x80 to 0x13.
  - Response: lb 0x13 gives 0xFFFFFF80; lbu 0x13 gives 0x00000080; lw 0x10 gives 0x80ADBEEF.
- Half lanes:
  - Stimulus: sh 0x8001 to 0x22.
  - Response: lh 0x22 gives 0xFFFF8001; lhu gives 0x00008001; lw 0x20 has bits [15:0] unchanged.
- Errors:
  - Stimulus: lw at 0x11; sh at 0x23; xfer_size=3; read and write both 1; addr=DEPTH*4.
  - Response: each returns rsp_err=1, rdata=0, and a following lw of the targeted word shows no change.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during a load, and present a second req_valid meanwhile.
  - Response: rsp_valid and rdata stay stable; req_ready=0 throughout; the second request is accepted only after the handshake.
- Mid-op reset:
  - Stimulus: store 0x12345678 to 0x40 over the old value 0; pulse rst_n low in the first ACCESS cycle.
  - Response: rsp_valid=0 and req_ready=1 immediately; a later lw 0x40 returns 0.
  - With DMEM_STATS_EN defined, all counters read 0 after the reset.
